// File: rtl/sram_banked_mp_if.sv
// Request/response bundle for sram_banked_mp. Per-port fields are flattened,
// and port i occupies slice i of each bus.
interface sram_banked_mp_if #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 6,
    parameter int ROW_WIDTH  = 80
);
    logic [NUM_PORTS-1:0]            req_valid;
    logic [NUM_PORTS-1:0]            req_ready;
    logic [NUM_PORTS-1:0]            req_we;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_PORTS*ROW_WIDTH-1:0]  req_wdata;
    logic [NUM_PORTS-1:0]            rsp_valid;
    logic [NUM_PORTS*ROW_WIDTH-1:0]  rsp_rdata;
    logic                            err_oob;

    modport master (output req_valid, req_we, req_addr, req_wdata,
                    input  req_ready, rsp_valid, rsp_rdata, err_oob);
    modport slave  (input  req_valid, req_we, req_addr, req_wdata,
                    output req_ready, rsp_valid, rsp_rdata, err_oob);
endinterface

// File: rtl/sram_banked_mp.sv
// Multi-port, bank-interleaved SRAM with one arbiter per bank and 1-cycle read latency.
// Define SRAM_BANKED_FIXED_PRIO_EN for fixed lowest-index priority; the default is round-robin.
module sram_banked_mp #(
    parameter int ROW_COUNT  = 64,
    parameter int ROW_WIDTH  = 80,
    parameter int NUM_PORTS  = 4,
    parameter int NUM_BANKS  = 4,
    parameter int ADDR_WIDTH = (ROW_COUNT > 1) ? $clog2(ROW_COUNT) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    sram_banked_mp_if.slave bus
);
    localparam int BANK_SHIFT = $clog2(NUM_BANKS);
    localparam int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int PTR_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int BANK_ROWS  = ROW_COUNT / NUM_BANKS;
    localparam int BROW_W     = (BANK_ROWS > 1) ? $clog2(BANK_ROWS) : 1;

    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] addr_s;
    logic [NUM_PORTS-1:0][ROW_WIDTH-1:0]  wdata_s;
    logic [BANK_W-1:0]                    bank_s [NUM_PORTS];
    logic [BROW_W-1:0]                    row_s  [NUM_PORTS];
    logic [NUM_PORTS-1:0]                 oob_s;
    logic [NUM_BANKS-1:0][NUM_PORTS-1:0]  bank_req_s;
    logic [NUM_BANKS-1:0]                 gnt_valid_s;
    logic [PTR_W-1:0]                     gnt_port_s [NUM_BANKS];
    logic [PTR_W-1:0]                     start_s    [NUM_BANKS];
    logic [NUM_PORTS-1:0]                 ready_s;

    logic [ROW_WIDTH-1:0]                 mem_q [NUM_BANKS][BANK_ROWS];
    logic [NUM_PORTS-1:0]                 rsp_valid_d, rsp_valid_q;
    logic [NUM_PORTS-1:0][ROW_WIDTH-1:0]  rsp_rdata_d, rsp_rdata_q;
    logic                                 err_oob_d, err_oob_q;

    function automatic logic [PTR_W-1:0] port_at(input logic [PTR_W-1:0] start,
                                                 input int unsigned    k);
        return PTR_W'((32'(start) + k) % 32'(NUM_PORTS));
    endfunction

    assign addr_s  = bus.req_addr;
    assign wdata_s = bus.req_wdata;

    // Address decode: low bits pick the bank, the rest pick the row inside it.
    always_comb begin
        bank_req_s = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            bank_s[p] = BANK_W'(addr_s[p] & ADDR_WIDTH'(NUM_BANKS - 1));
            row_s[p]  = BROW_W'(addr_s[p] >> BANK_SHIFT);
            oob_s[p]  = 32'(addr_s[p]) >= 32'(ROW_COUNT);
            bank_req_s[bank_s[p]][p] = bus.req_valid[p];
        end
    end

`ifdef SRAM_BANKED_FIXED_PRIO_EN
    // Fixed priority: every bank scans from port 0.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            start_s[b] = '0;
        end
    end
`else
    logic [PTR_W-1:0] ptr_q [NUM_BANKS];
    logic [PTR_W-1:0] ptr_d [NUM_BANKS];

    // Round-robin: scan starts at the bank pointer, which moves past each winner.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            start_s[b] = ptr_q[b];
            if (gnt_valid_s[b]) begin
                ptr_d[b] = (gnt_port_s[b] == PTR_W'(NUM_PORTS - 1)) ? '0
                                                                    : gnt_port_s[b] + PTR_W'(1);
            end else begin
                ptr_d[b] = ptr_q[b];
            end
        end
    end

    // Per-bank arbitration pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                ptr_q[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                ptr_q[b] <= ptr_d[b];
            end
        end
    end
`endif

    // Grant selection: walk the scan order backwards so the earliest requester wins.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            gnt_valid_s[b] = 1'b0;
            gnt_port_s[b]  = '0;
            for (int k = NUM_PORTS - 1; k >= 0; k--) begin
                gnt_port_s[b]  = bank_req_s[b][port_at(start_s[b], k)] ? port_at(start_s[b], k)
                                                                       : gnt_port_s[b];
                gnt_valid_s[b] = gnt_valid_s[b] | bank_req_s[b][port_at(start_s[b], k)];
            end
        end
    end

    // A port is ready when its bank granted it; nothing is accepted during reset.
    always_comb begin
        ready_s = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                ready_s[p] = ready_s[p] | (gnt_valid_s[b] & (gnt_port_s[b] == PTR_W'(p)));
            end
        end
        ready_s = ready_s & {NUM_PORTS{rst_n}};
    end

    // Read responses for the next cycle plus the sticky out-of-range flag.
    always_comb begin
        rsp_valid_d = '0;
        rsp_rdata_d = '0;
        err_oob_d   = err_oob_q;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (ready_s[p] && !bus.req_we[p]) begin
                rsp_valid_d[p] = 1'b1;
                rsp_rdata_d[p] = oob_s[p] ? '0 : mem_q[bank_s[p]][row_s[p]];
            end else begin
                rsp_valid_d[p] = 1'b0;
                rsp_rdata_d[p] = '0;
            end
            err_oob_d = err_oob_d | (ready_s[p] & oob_s[p]);
        end
    end

    // Response and error registers; a pending read is dropped when reset hits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            err_oob_q   <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            err_oob_q   <= err_oob_d;
        end
    end

    // Storage keeps its contents across reset; out-of-range writes are discarded.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (ready_s[p] && bus.req_we[p] && !oob_s[p]) begin
                mem_q[bank_s[p]][row_s[p]] <= wdata_s[p];
            end
        end
    end

    assign bus.req_ready = ready_s;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.err_oob   = err_oob_q;

endmodule

// File: tb/tb_sram_banked_mp.sv
// Bench for sram_banked_mp: a 64-row and a 48-row instance share one stimulus stream
// and are checked against a flat-array, scan-order reference model.
`timescale 1ns/1ps
module tb_sram_banked_mp;
    localparam int NP = 4;
    localparam int NB = 4;
    localparam int RW = 80;
    localparam int AW = 6;

    logic clk;
    logic rst_n;
    logic [NP-1:0]    tb_valid;
    logic [NP-1:0]    tb_we;
    logic [AW-1:0]    tb_addr  [NP];
    logic [RW-1:0]    tb_wdata [NP];
    logic [NP*AW-1:0] addr_flat;
    logic [NP*RW-1:0] wdata_flat;

    sram_banked_mp_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .ROW_WIDTH(RW)) bus64 ();
    sram_banked_mp_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .ROW_WIDTH(RW)) bus48 ();

    always_comb begin
        for (int p = 0; p < NP; p++) begin
            addr_flat[p*AW +: AW]  = tb_addr[p];
            wdata_flat[p*RW +: RW] = tb_wdata[p];
        end
    end

    assign bus64.req_valid = tb_valid;
    assign bus64.req_we    = tb_we;
    assign bus64.req_addr  = addr_flat;
    assign bus64.req_wdata = wdata_flat;
    assign bus48.req_valid = tb_valid;
    assign bus48.req_we    = tb_we;
    assign bus48.req_addr  = addr_flat;
    assign bus48.req_wdata = wdata_flat;

    sram_banked_mp #(.ROW_COUNT(64), .ROW_WIDTH(RW), .NUM_PORTS(NP), .NUM_BANKS(NB),
                     .ADDR_WIDTH(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus64));
    sram_banked_mp #(.ROW_COUNT(48), .ROW_WIDTH(RW), .NUM_PORTS(NP), .NUM_BANKS(NB),
                     .ADDR_WIDTH(AW)) dut48 (.clk(clk), .rst_n(rst_n), .bus(bus48));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [RW-1:0]    mem_m [2][64];
    int               ptr_m [NB];
    logic             err_m [2];
    logic [NP-1:0]    rv_m  [2];
    logic [NP*RW-1:0] rd_m  [2];
    logic [NP-1:0]    exp_ready;
    logic [NP-1:0]    obs_ready;
    int               wait_cnt [NP];

    task automatic check_eq(input string tag, input logic [NP*RW-1:0] obs,
                            input logic [NP*RW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int rows_of(input int d);
        return (d == 0) ? 64 : 48;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < NB; b++) ptr_m[b] = 0;
        for (int d = 0; d < 2; d++) begin
            err_m[d] = 1'b0;
            rv_m[d]  = '0;
            rd_m[d]  = '0;
        end
        for (int p = 0; p < NP; p++) wait_cnt[p] = 0;
    endtask

    task automatic set_req(input int p, input bit v, input bit we, input int a,
                           input logic [RW-1:0] data);
        tb_valid[p] = v;
        tb_we[p]    = we;
        tb_addr[p]  = AW'(a);
        tb_wdata[p] = data;
    endtask

    task automatic drop_accepted();
        for (int p = 0; p < NP; p++) begin
            if (obs_ready[p]) tb_valid[p] = 1'b0;
        end
    endtask

    // One clock: check grants, advance the model, check responses after the edge.
    task automatic run_cycle();
        @(negedge clk);
        exp_ready = '0;
        for (int b = 0; b < NB; b++) begin
            int start;
            bit found;
`ifdef SRAM_BANKED_FIXED_PRIO_EN
            start = 0;
`else
            start = ptr_m[b];
`endif
            found = 1'b0;
            for (int k = 0; k < NP; k++) begin
                int p;
                p = (start + k) % NP;
                if (!found && tb_valid[p] && ((int'(tb_addr[p]) % NB) == b)) begin
                    found = 1'b1;
                    exp_ready[p] = 1'b1;
`ifndef SRAM_BANKED_FIXED_PRIO_EN
                    ptr_m[b] = (p + 1) % NP;
`endif
                end
            end
        end
        obs_ready = bus64.req_ready;
        check_eq("ready", bus64.req_ready, exp_ready);
        check_eq("ready48", bus48.req_ready, exp_ready);
`ifndef SRAM_BANKED_FIXED_PRIO_EN
        for (int p = 0; p < NP; p++) begin
            if (tb_valid[p] && !obs_ready[p]) begin
                wait_cnt[p]++;
            end else begin
                if (tb_valid[p]) check_eq("wait_bound", (wait_cnt[p] <= NP - 1), 1'b1);
                wait_cnt[p] = 0;
            end
        end
`endif
        for (int d = 0; d < 2; d++) begin
            rv_m[d] = '0;
            rd_m[d] = '0;
            for (int p = 0; p < NP; p++) begin
                int a;
                a = int'(tb_addr[p]);
                if (exp_ready[p]) begin
                    if (a >= rows_of(d)) err_m[d] = 1'b1;
                    if (!tb_we[p]) begin
                        rv_m[d][p] = 1'b1;
                        rd_m[d][p*RW +: RW] = (a < rows_of(d)) ? mem_m[d][a] : '0;
                    end
                end
            end
            for (int p = 0; p < NP; p++) begin
                int a;
                a = int'(tb_addr[p]);
                if (exp_ready[p] && tb_we[p] && (a < rows_of(d))) mem_m[d][a] = tb_wdata[p];
            end
        end
        @(posedge clk);
        #1;
        check_eq("rsp_valid", bus64.rsp_valid, rv_m[0]);
        check_eq("rsp_rdata", bus64.rsp_rdata, rd_m[0]);
        check_eq("err_oob", bus64.err_oob, err_m[0]);
        check_eq("rsp_valid48", bus48.rsp_valid, rv_m[1]);
        check_eq("rsp_rdata48", bus48.rsp_rdata, rd_m[1]);
        check_eq("err_oob48", bus48.err_oob, err_m[1]);
    endtask

    task automatic refresh_random();
        for (int p = 0; p < NP; p++) begin
            if (obs_ready[p] || !tb_valid[p]) begin
                tb_valid[p] = ($urandom_range(0, 3) != 0);
                tb_we[p]    = ($urandom_range(0, 1) == 1);
                tb_addr[p]  = AW'($urandom_range(0, 63));
                tb_wdata[p] = {16'($urandom), $urandom, $urandom};
            end
        end
    endtask

    logic [RW-1:0] a5_data;
    logic [RW-1:0] oob_data;

    initial begin
        a5_data  = 80'hA5A5_A5A5_A5A5_A5A5_A5A5;
        oob_data = 80'h1234_5678_9ABC_DEF0_0F0F;
        rst_n    = 1'b1;
        tb_valid = '0;
        tb_we    = '0;
        obs_ready = '0;
        for (int p = 0; p < NP; p++) begin
            tb_addr[p]  = '0;
            tb_wdata[p] = '0;
        end
        model_reset();

        // Reset values and ready held low during reset
        #1 rst_n = 1'b0;
        #2;
        check_eq("rst_rsp_valid", bus64.rsp_valid, '0);
        check_eq("rst_rsp_rdata", bus64.rsp_rdata, '0);
        check_eq("rst_err_oob", bus48.err_oob, 1'b0);
        for (int p = 0; p < NP; p++) set_req(p, 1'b1, 1'b0, p, '0);
        @(negedge clk);
        check_eq("rst_ready", bus64.req_ready, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tb_valid = '0;
        model_reset();

        // Fill rows 0..47 with one write per bank each cycle
        for (int k = 0; k < 12; k++) begin
            for (int p = 0; p < NP; p++)
                set_req(p, 1'b1, 1'b1, 4 * k + p, {16'($urandom), $urandom, $urandom});
            run_cycle();
        end
        tb_valid = '0;

        // Write then read-back through another port
        set_req(0, 1'b1, 1'b1, 5, a5_data);
        run_cycle();
        check_eq("a5_wr_ready", obs_ready[0], 1'b1);
        tb_valid = '0;
        set_req(1, 1'b1, 1'b0, 5, '0);
        run_cycle();
        check_eq("a5_rsp_valid", bus64.rsp_valid[1], 1'b1);
        check_eq("a5_rdata", bus64.rsp_rdata[RW +: RW], a5_data);
        check_eq("a5_p0_zero", bus64.rsp_rdata[0 +: RW], '0);
        tb_valid = '0;

        // Four banks in parallel
        for (int p = 0; p < NP; p++) set_req(p, 1'b1, 1'b0, p, '0);
        run_cycle();
        check_eq("par_ready", obs_ready, 4'hF);
        check_eq("par_valid", bus64.rsp_valid, 4'hF);
        tb_valid = '0;

        // Bank-0 conflict from fresh pointers, then re-issue ports 2 and 0
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        for (int p = 0; p < NP; p++) set_req(p, 1'b1, 1'b0, 4 * p, '0);
        for (int i = 0; i < NP; i++) begin
            run_cycle();
            check_eq("rr_order", obs_ready, 4'b0001 << i);
            drop_accepted();
        end
        set_req(2, 1'b1, 1'b0, 8, '0);
        set_req(0, 1'b1, 1'b0, 0, '0);
        run_cycle();
        check_eq("rr_p0_first", obs_ready, 4'b0001);
        drop_accepted();
        run_cycle();
        check_eq("rr_p2_next", obs_ready, 4'b0100);
        drop_accepted();

        // Ports 0 and 2 keep requesting bank 1
        set_req(0, 1'b1, 1'b0, 1, '0);
        set_req(2, 1'b1, 1'b0, 5, '0);
        for (int i = 0; i < 4; i++) begin
            run_cycle();
`ifdef SRAM_BANKED_FIXED_PRIO_EN
            check_eq("b1_share", obs_ready, 4'b0001);
`else
            check_eq("b1_share", obs_ready, ((i % 2) == 0) ? 4'b0001 : 4'b0100);
`endif
        end
        tb_valid[0] = 1'b0;
        run_cycle();
        check_eq("b1_p2_after_drop", obs_ready, 4'b0100);
        tb_valid = '0;

        // Out-of-range access on the 48-row instance
        check_eq("oob_err_clear", bus48.err_oob, 1'b0);
        set_req(0, 1'b1, 1'b1, 50, oob_data);
        run_cycle();
        check_eq("oob_err_set", bus48.err_oob, 1'b1);
        tb_valid = '0;
        set_req(0, 1'b1, 1'b0, 50, '0);
        run_cycle();
        check_eq("oob_rd_valid", bus48.rsp_valid[0], 1'b1);
        check_eq("oob_rd_zero", bus48.rsp_rdata[0 +: RW], '0);
        check_eq("oob_rd_64", bus64.rsp_rdata[0 +: RW], oob_data);
        tb_valid = '0;
        run_cycle();
        run_cycle();
        check_eq("oob_sticky", bus48.err_oob, 1'b1);

        // Reset right after a read is accepted
        set_req(2, 1'b1, 1'b0, 8, '0);
        run_cycle();
        check_eq("pre_rst_valid", bus64.rsp_valid[2], 1'b1);
        tb_valid = '0;
        rst_n = 1'b0;
        #1;
        check_eq("rst_drop_valid", bus64.rsp_valid, '0);
        check_eq("rst_clr_err48", bus48.err_oob, 1'b0);
        set_req(1, 1'b1, 1'b0, 4, '0);
        set_req(3, 1'b1, 1'b0, 12, '0);
        @(negedge clk);
        check_eq("rst_ready2", bus64.req_ready, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        tb_valid = '0;
        run_cycle();
        check_eq("post_rst_quiet", bus64.rsp_valid, '0);
        tb_valid[1] = 1'b1;
        tb_valid[3] = 1'b1;
        run_cycle();
        check_eq("post_rst_p1", obs_ready, 4'b0010);
        drop_accepted();
        run_cycle();
        check_eq("post_rst_p3", obs_ready, 4'b1000);
        tb_valid = '0;

        // Fill rows 48..63, then random traffic
        for (int k = 12; k < 16; k++) begin
            for (int p = 0; p < NP; p++)
                set_req(p, 1'b1, 1'b1, 4 * k + p, {16'($urandom), $urandom, $urandom});
            run_cycle();
        end
        tb_valid = '0;
        obs_ready = '0;
        for (int i = 0; i < 400; i++) begin
            refresh_random();
            run_cycle();
        end
        tb_valid = '0;
        run_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sram_banked_mp.md
# sram_banked_mp

Multi-port, bank-interleaved SRAM with per-bank round-robin arbitration and a valid/ready request interface. It generalises the single-address and fixed-mapping scratchpads used by the MHA datapath. Any of `NUM_PORTS` clients (Q/K/V producers, score readers) may issue a read or write to any row each cycle; requests to distinct banks proceed in parallel, and same-bank conflicts are serialised fairly.

## Interface
Parameters:
- `ROW_COUNT`, 64, number of rows; must be a multiple of `NUM_BANKS`.
- `ROW_WIDTH`, 80, bits per row.
- `NUM_PORTS`, 4, number of request ports (≥1).
- `NUM_BANKS`, 4, number of banks (power of two, ≥1).
- `ADDR_WIDTH`, `$clog2(ROW_COUNT)`, row address width (1 when `ROW_COUNT`=1).

Ports (per-port buses are flattened; port i occupies slice i):
- `clk`  in  1  clock. Single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_PORTS  request present.
- `req_ready`  out  NUM_PORTS  request accepted this cycle.
- `req_we`  in  NUM_PORTS  1 = write, 0 = read.
- `req_addr`  in  NUM_PORTS*ADDR_WIDTH  row address.
- `req_wdata`  in  NUM_PORTS*ROW_WIDTH  write data.
- `rsp_valid`  out  NUM_PORTS  read data valid.
- `rsp_rdata`  out  NUM_PORTS*ROW_WIDTH  read data.
- `err_oob`  out  1  sticky flag: an accepted request had `addr ≥ ROW_COUNT`.

## Operation
- Bank select: `addr % NUM_BANKS`. Row within the bank: `addr / NUM_BANKS`.
- Each bank services at most one request per cycle. One arbiter per bank, with a pointer `ptr_b` of width `$clog2(NUM_PORTS)`.
- Round-robin grant:
  - The winner is the first port with a valid request to bank b, scanning `ptr_b, ptr_b+1, … mod NUM_PORTS`.
  - On a grant, `ptr_b ← (winner+1) mod NUM_PORTS`.
  - With no grant, `ptr_b` holds.
- `req_ready[i]` is asserted only when port i is granted. A transfer occurs when `req_valid & req_ready`.
- `req_ready` is a combinational function of `req_valid`, `req_addr` and the pointers.
- A master must hold `valid`, `we`, `addr` and `wdata` stable until ready.
- Accepted write: the bank row is updated at that clock edge. No response is generated.
- Accepted read:
  - `rsp_valid[i]` is 1 in the following cycle, and `rsp_rdata[i]` carries the row contents.
  - A port with no read accepted drives `rsp_valid`=0 and `rsp_rdata`=0 in the next cycle.
- Same-cycle read and write to one address cannot occur, because they hit the same bank.
- A read accepted in the cycle after a write returns the new data.
- Out-of-range address (possible only when `ROW_COUNT` is not a power of two):
  - The request is accepted normally.
  - A write is discarded.
  - A read returns `rsp_valid`=1 with data 0.
  - `err_oob` is set and remains set until reset.
- Memory contents are not reset.

## Timing
- Reset (async assert, sync deassert handled upstream):
  - `rsp_valid`=0, `rsp_rdata`=0, `err_oob`=0, all `ptr_b`=0.
  - `req_ready` is forced to 0 while `rst_n`=0.
- Read latency is 1 cycle from the accepting edge to `rsp_valid`. Responses are never back-pressured.
- Peak throughput is `min(NUM_PORTS, NUM_BANKS)` requests per cycle.
- Worst-case wait for a held request is `NUM_PORTS-1` cycles (round-robin).
- Reset asserted mid-operation:
  - Pending responses are dropped: `rsp_valid` is 0 immediately, with no glitching response after release.
  - Writes accepted before reset assertion remain in memory.

## Configuration
- `SRAM_BANKED_FIXED_PRIO_EN`
  - Defined: each bank uses fixed priority, where the lowest-index requesting port wins. Pointers are removed.
  - Undefined (default): round-robin as above.

## Test plan
- Write port0 addr 5 data `0x…A5`. The next cycle, read port1 addr 5 → `rsp_valid[1]`=1 one cycle after acceptance, data `0x…A5`. `rsp_rdata[0]`=0.
- Ports 0–3 read addrs 0, 1, 2, 3 in the same cycle → all `req_ready`=1 in that cycle. All `rsp_valid`=1 in the next cycle with the correct rows.
- Ports 0–3 all hold reads to bank 0 (addrs 0, 4, 8, 12) → grants in order 0, 1, 2, 3 on successive cycles. Re-issuing ports 2 and 0 after `ptr_0`=0 → port 0 first, then port 2.
- `ROW_COUNT`=48: read addr 50 → `rsp_valid`=1, data 0, `err_oob`=1. A write to addr 50 leaves all rows unchanged. `err_oob` stays 1 until `rst_n`=0.
- Reset mid-burst: read accepted, then `rst_n`=0 before the next edge → `rsp_valid`=0. After release, a bank-0 conflict between ports 1 and 3 grants port 1 first (`ptr`=0).
- `SRAM_BANKED_FIXED_PRIO_EN` defined: ports 0 and 2 continuously request bank 1 → port 0 granted every cycle, port 2 only after port 0 drops valid.
